scalu_mq: RTL and testbench

Parametrised scalar ALU for the exers→wb path: single-cycle integer ops plus an optional iterative multiply/divide unit, with a QDEPTH-entry result queue so writeback backpressure does not stall issue at once. Sits between the exers issue port and the wb arbiter and shares the same valid/stall handshake and rob_flush semantics.

---
 rtl/scalu_pkg.sv | 33 +++
 rtl/scalu_muldiv.sv | 97 +++++++++
 rtl/scalu_mq.sv | 212 +++++++++++++++++++++
 tb/tb_scalu_mq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scalu_pkg.sv
// scalu_pkg: shared constants for the scalar ALU / result queue block.
//   - opcode field positions and op[2:0] function codes for the single-cycle group
//   - op[1:0] function codes for the multiply/divide group
//   - exception cause codes
//   - IDLE/BUSY state encoding of the multiply/divide sequencer
package scalu_pkg;

    localparam int OP_MD_BIT  = 4;   // 1: multiply/divide group
    localparam int OP_ALT_BIT = 3;   // selects SUB / SRA

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_MULHU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_REMU  = 2'b11;

    localparam logic [4:0] ECAUSE_NONE    = 5'd0;
    localparam logic [4:0] ECAUSE_ILLEGAL = 5'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/scalu_muldiv.sv
// scalu_muldiv: iterative unsigned multiply / divide unit, one bit per cycle.
// Only instantiated when SCALU_MULDIV_EN is defined.
//   clk, rst      clock, async active-low reset
//   start_i       load operands and begin (ignored while aborting)
//   abort_i       drop the operation in flight
//   func_i        MUL / MULHU / DIVU / REMU
//   a_i, b_i      op1, op2 (multiplicand/multiplier, dividend/divisor)
//   done_o        high during the last iteration; result_o valid with it
//   result_o      final result, combinational from the last iteration
module scalu_muldiv
    import scalu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [1:0]      func_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       func_q;
    logic [XLEN-1:0]  b_q;
    // hi: running partial product high half / partial remainder
    // lo: multiplier being shifted out / dividend shifted out, quotient shifted in
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN:0]    sum, shifted, diff;

    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        hi_d    = sum[XLEN:1];
        lo_d    = {sum[0], lo_q[XLEN-1:1]};
        if (func_q[1]) begin
            // Restoring step. A zero divisor never borrows, which yields
            // quotient all-ones and remainder equal to the dividend.
            if (diff[XLEN]) begin
                hi_d = shifted[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                hi_d = diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        result_o = lo_d;
        unique case (func_q)
            MD_MUL:   result_o = lo_d;
            MD_MULHU: result_o = hi_d;
            MD_DIVU:  result_o = lo_d;
            MD_REMU:  result_o = hi_d;
        endcase
    end

    assign done_o = busy_q & (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            func_q <= MD_MUL;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(XLEN - 1);
            func_q <= func_i;
            b_q    <= b_i;
            hi_q   <= '0;
            lo_q   <= a_i;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/scalu_mq.sv
// scalu_mq: scalar ALU between the exers issue port and the wb arbiter.
// Single-cycle integer ops write a QDEPTH-entry result FIFO; the FIFO head
// drives all scalu_* outputs (zeroed while the FIFO is empty).
// Optional feature macro: SCALU_MULDIV_EN enables the iterative
// MUL/MULHU/DIVU/REMU unit; without it every op[4]=1 is illegal.
//
// Ports:
//   clk, rst                       clock, async active-low reset
//   exers_scalu_issue/op/robid/rd  issue strobe, opcode, ROB id, dest tag
//   exers_op1, exers_op2           operands
//   scalu_stall                    issue blocked (queue full or unit busy)
//   scalu_valid/error/ecause       head valid, head faulted, fault cause
//   scalu_robid/rd/result          head ROB id, dest tag, result
//   wb_scalu_stall                 wb refuses the head this cycle
//   rob_flush                      discard queue and in-flight work
//
// Multiply/divide sequencer states:
//   state   | meaning
//   ST_IDLE | accepting issues
//   ST_BUSY | iterating a muldiv op; result enqueued on the last iteration
module scalu_mq
    import scalu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ROBID_W = 8,
    parameter int RD_W    = 6,
    parameter int QDEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exers_scalu_issue,
    input  logic [4:0]         exers_scalu_op,
    input  logic [ROBID_W-1:0] exers_robid,
    input  logic [RD_W-1:0]    exers_rd,
    input  logic [XLEN-1:0]    exers_op1,
    input  logic [XLEN-1:0]    exers_op2,
    output logic               scalu_stall,
    output logic               scalu_valid,
    output logic               scalu_error,
    output logic [4:0]         scalu_ecause,
    output logic [ROBID_W-1:0] scalu_robid,
    output logic [RD_W-1:0]    scalu_rd,
    output logic [XLEN-1:0]    scalu_result,
    input  logic               wb_scalu_stall,
    input  logic               rob_flush
);

    localparam int SH_W  = $clog2(XLEN);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic               accept, illegal, push_issue, push, pop, full;
    logic [SH_W-1:0]    shamt;
    logic [XLEN-1:0]    alu_res;

    logic               push_err;
    logic [4:0]         push_ecause;
    logic [ROBID_W-1:0] push_robid;
    logic [RD_W-1:0]    push_rd;
    logic [XLEN-1:0]    push_result;

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               q_err    [QDEPTH];
    logic [4:0]         q_ecause [QDEPTH];
    logic [ROBID_W-1:0] q_robid  [QDEPTH];
    logic [RD_W-1:0]    q_rd     [QDEPTH];
    logic [XLEN-1:0]    q_result [QDEPTH];

    // An issue in the flush cycle is dropped.
    assign accept = exers_scalu_issue & ~scalu_stall & ~rob_flush;
    assign full   = (count_q == CNT_W'(QDEPTH));
    assign pop    = scalu_valid & ~wb_scalu_stall;

    // ---------------- single-cycle datapath ----------------
    assign shamt = exers_op2[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        unique case (exers_scalu_op[2:0])
            F3_ADD:  alu_res = exers_scalu_op[OP_ALT_BIT] ? (exers_op1 - exers_op2)
                                                          : (exers_op1 + exers_op2);
            F3_SLL:  alu_res = exers_op1 << shamt;
            F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(exers_op1) < $signed(exers_op2))};
            F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (exers_op1 < exers_op2)};
            F3_XOR:  alu_res = exers_op1 ^ exers_op2;
            F3_SRL:  alu_res = exers_scalu_op[OP_ALT_BIT] ? XLEN'($signed(exers_op1) >>> shamt)
                                                          : (exers_op1 >> shamt);
            F3_OR:   alu_res = exers_op1 | exers_op2;
            F3_AND:  alu_res = exers_op1 & exers_op2;
        endcase
    end

`ifdef SCALU_MULDIV_EN
    // ---------------- multiply/divide sequencer ----------------
    state_e             state_q, state_d;
    logic               md_op, md_start, md_done, md_push;
    logic [XLEN-1:0]    md_result;
    logic [ROBID_W-1:0] md_robid_q;
    logic [RD_W-1:0]    md_rd_q;

    assign illegal     = exers_scalu_op[OP_MD_BIT] & exers_scalu_op[2];
    assign md_op       = exers_scalu_op[OP_MD_BIT] & ~exers_scalu_op[2];
    assign md_start    = accept & md_op;
    assign push_issue  = accept & ~md_op;
    // Slot is guaranteed: the queue was not full at issue and nothing else
    // enqueues while busy.
    assign md_push     = md_done & (state_q == ST_BUSY) & ~rob_flush;
    assign push        = push_issue | md_push;
    assign scalu_stall = full | (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (md_start) state_d = ST_BUSY;
            ST_BUSY: if (md_done)  state_d = ST_IDLE;
        endcase
        if (rob_flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            md_robid_q <= '0;
            md_rd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (md_start) begin
                md_robid_q <= exers_robid;
                md_rd_q    <= exers_rd;
            end
        end
    end

    scalu_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .abort_i  (rob_flush),
        .func_i   (exers_scalu_op[1:0]),
        .a_i      (exers_op1),
        .b_i      (exers_op2),
        .done_o   (md_done),
        .result_o (md_result)
    );
`else
    assign illegal     = exers_scalu_op[OP_MD_BIT];
    assign push_issue  = accept;
    assign push        = push_issue;
    assign scalu_stall = full;
`endif

    // ---------------- enqueue data select ----------------
    always_comb begin
        push_err    = illegal;
        push_ecause = illegal ? ECAUSE_ILLEGAL : ECAUSE_NONE;
        push_robid  = exers_robid;
        push_rd     = exers_rd;
        push_result = illegal ? '0 : alu_res;
`ifdef SCALU_MULDIV_EN
        if (md_push) begin
            push_err    = 1'b0;
            push_ecause = ECAUSE_NONE;
            push_robid  = md_robid_q;
            push_rd     = md_rd_q;
            push_result = md_result;
        end
`endif
    end

    // ---------------- result queue ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (rob_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            q_err[wr_ptr_q]    <= push_err;
            q_ecause[wr_ptr_q] <= push_ecause;
            q_robid[wr_ptr_q]  <= push_robid;
            q_rd[wr_ptr_q]     <= push_rd;
            q_result[wr_ptr_q] <= push_result;
        end
    end

    assign scalu_valid  = (count_q != '0);
    assign scalu_error  = scalu_valid ? q_err[rd_ptr_q]    : 1'b0;
    assign scalu_ecause = scalu_valid ? q_ecause[rd_ptr_q] : ECAUSE_NONE;
    assign scalu_robid  = scalu_valid ? q_robid[rd_ptr_q]  : '0;
    assign scalu_rd     = scalu_valid ? q_rd[rd_ptr_q]     : '0;
    assign scalu_result = scalu_valid ? q_result[rd_ptr_q] : '0;

endmodule

// File: tb/tb_scalu_mq.sv
module tb_scalu_mq;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue = 1'b0;
    logic [4:0]  op = '0;
    logic [7:0]  robid = '0;
    logic [5:0]  rd = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic        wb_stall = 1'b0;
    logic        flush = 1'b0;

    logic        stall, valid, err;
    logic [4:0]  ecause;
    logic [7:0]  o_robid;
    logic [5:0]  o_rd;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    logic [4:0]  v_op [10];
    logic [31:0] v_a  [10];
    logic [31:0] v_b  [10];
    logic [31:0] v_e  [10];

    scalu_mq #(.XLEN(32), .ROBID_W(8), .RD_W(6), .QDEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .exers_scalu_issue (issue),
        .exers_scalu_op    (op),
        .exers_robid       (robid),
        .exers_rd          (rd),
        .exers_op1         (op1),
        .exers_op2         (op2),
        .scalu_stall       (stall),
        .scalu_valid       (valid),
        .scalu_error       (err),
        .scalu_ecause      (ecause),
        .scalu_robid       (o_robid),
        .scalu_rd          (o_rd),
        .scalu_result      (o_result),
        .wb_scalu_stall    (wb_stall),
        .rob_flush         (flush)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] rb, input logic [5:0] r);
        issue = 1'b1; op = o; op1 = a; op2 = b; robid = rb; rd = r;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b exp 0", valid); end
        checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
        checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_error: got %b exp 0", err); end
        checks++; if (ecause !== 5'd0) begin errors++; $display("FAIL reset_ecause: got %0d exp 0", ecause); end
        checks++; if (o_robid !== 8'd0 || o_rd !== 6'd0 || o_result !== 32'd0) begin
            errors++; $display("FAIL reset_data: got robid %h rd %h result %h exp 0", o_robid, o_rd, o_result);
        end
        rst = 1'b1;
        step();
    endtask

    // Back-to-back issue with wb draining: each result appears one cycle later.
    task automatic test_alu();
        v_op = '{5'b00000, 5'b01000, 5'b01101, 5'b00101, 5'b00001,
                 5'b00010, 5'b00011, 5'b00100, 5'b00110, 5'b00111};
        v_a  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd1,
                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
        v_b  = '{32'd7, 32'd7, 32'd4, 32'd4, 32'd33,
                 32'd1, 32'd1, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00};
        v_e  = '{32'd12, 32'hFFFFFFFE, 32'hF8000000, 32'h08000000, 32'd2,
                 32'd1, 32'd0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'hF000F000};
        for (int i = 0; i < 10; i++) begin
            drive(v_op[i], v_a[i], v_b[i], 8'(3 + i), 6'(9 + i));
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall[%0d]: got %b exp 0", i, stall); end
            step();
            issue = 1'b0;
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL alu_valid[%0d]: got %b exp 1", i, valid); end
            checks++; if (o_result !== v_e[i]) begin errors++; $display("FAIL alu_result[%0d]: got %h exp %h", i, o_result, v_e[i]); end
            checks++; if (o_robid !== 8'(3 + i) || o_rd !== 6'(9 + i)) begin
                errors++; $display("FAIL alu_tags[%0d]: got robid %0d rd %0d exp %0d %0d", i, o_robid, o_rd, 3 + i, 9 + i);
            end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL alu_error[%0d]: got %b exp 0", i, err); end
        end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL alu_drain: valid %b exp 0", valid); end
    endtask

    task automatic test_back_to_back();
        wb_stall = 1'b1;
        drive(5'b00000, 32'd1, 32'd1, 8'd1, 6'd1);
        step();
        drive(5'b00000, 32'd2, 32'd2, 8'd2, 6'd2);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall1: got %b exp 0", stall); end
        step();
        drive(5'b00000, 32'd3, 32'd3, 8'd3, 6'd3);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_full_stall: got %b exp 1", stall); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (o_result !== 32'd2 || o_robid !== 8'd1 || valid !== 1'b1) begin
                errors++; $display("FAIL b2b_head_hold[%0d]: got %h robid %0d valid %b exp 2 1 1", i, o_result, o_robid, valid);
            end
            step();
        end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_still_full: got %b exp 1", stall); end
        wb_stall = 1'b0;
        step();
        checks++; if (o_result !== 32'd4 || o_robid !== 8'd2) begin
            errors++; $display("FAIL b2b_second: got %h robid %0d exp 4 2", o_result, o_robid);
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_unstall: got %b exp 0", stall); end
        step();
        issue = 1'b0;
        checks++; if (o_result !== 32'd6 || o_robid !== 8'd3 || valid !== 1'b1) begin
            errors++; $display("FAIL b2b_third: got %h robid %0d valid %b exp 6 3 1", o_result, o_robid, valid);
        end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: valid %b exp 0", valid); end
    endtask

    // op[4]=1 with op[2]=1 is illegal in every build.
    task automatic test_illegal();
        drive(5'b10100, 32'd9, 32'd9, 8'h21, 6'h11);
        step();
        issue = 1'b0;
        checks++; if (valid !== 1'b1 || err !== 1'b1 || ecause !== 5'd2 || o_result !== 32'd0 || o_robid !== 8'h21) begin
            errors++; $display("FAIL illegal_10100: got v%b e%b c%0d r%h id%h exp 1 1 2 0 21", valid, err, ecause, o_result, o_robid);
        end
        drive(5'b11111, 32'd9, 32'd9, 8'h22, 6'h12);
        step();
        issue = 1'b0;
        checks++; if (valid !== 1'b1 || err !== 1'b1 || ecause !== 5'd2 || o_result !== 32'd0) begin
            errors++; $display("FAIL illegal_11111: got v%b e%b c%0d r%h exp 1 1 2 0", valid, err, ecause, o_result);
        end
        step();
    endtask

    task automatic test_muldiv();
`ifdef SCALU_MULDIV_EN
        v_op[0:5] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10010, 5'b10011};
        v_a[0:5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd100, 32'd100};
        v_b[0:5]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'd7, 32'd7};
        v_e[0:5]  = '{32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF, 32'd7, 32'd14, 32'd2};
        for (int i = 0; i < 6; i++) begin
            drive(v_op[i], v_a[i], v_b[i], 8'(8'h50 + i), 6'(6'h20 + i));
            step();
            issue = 1'b0;
            for (int c = 0; c < XLEN; c++) begin
                checks++; if (stall !== 1'b1 || valid !== 1'b0) begin
                    errors++; $display("FAIL md_busy[%0d] cyc %0d: stall %b valid %b exp 1 0", i, c, stall, valid);
                end
                step();
            end
            checks++; if (valid !== 1'b1 || stall !== 1'b0 || err !== 1'b0) begin
                errors++; $display("FAIL md_done[%0d]: valid %b stall %b err %b exp 1 0 0", i, valid, stall, err);
            end
            checks++; if (o_result !== v_e[i]) begin errors++; $display("FAIL md_result[%0d]: got %h exp %h", i, o_result, v_e[i]); end
            checks++; if (o_robid !== 8'(8'h50 + i) || o_rd !== 6'(6'h20 + i)) begin
                errors++; $display("FAIL md_tags[%0d]: got %h %h", i, o_robid, o_rd);
            end
        end
        step();
`else
        v_op[0:2] = '{5'b10000, 5'b10001, 5'b10011};
        for (int i = 0; i < 3; i++) begin
            drive(v_op[i], 32'hFFFFFFFF, 32'd2, 8'(8'h60 + i), 6'(6'h30 + i));
            step();
            issue = 1'b0;
            checks++; if (valid !== 1'b1 || err !== 1'b1 || ecause !== 5'd2 || o_result !== 32'd0 || stall !== 1'b0) begin
                errors++; $display("FAIL md_illegal[%0d]: got v%b e%b c%0d r%h s%b exp 1 1 2 0 0", i, valid, err, ecause, o_result, stall);
            end
            checks++; if (o_robid !== 8'(8'h60 + i)) begin errors++; $display("FAIL md_illegal_robid[%0d]: got %h", i, o_robid); end
        end
        step();
`endif
    endtask

    task automatic test_flush();
        wb_stall = 1'b1;
        drive(5'b00000, 32'd10, 32'd1, 8'd7, 6'd7);
        step();
        drive(5'b00000, 32'd20, 32'd1, 8'd8, 6'd8);
        step();
        drive(5'b00000, 32'd30, 32'd1, 8'd9, 6'd9);
        flush = 1'b1;
        step();
        flush = 1'b0; issue = 1'b0;
        checks++; if (valid !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL flush_full: valid %b stall %b exp 0 0", valid, stall);
        end
        wb_stall = 1'b0;
        drive(5'b00000, 32'd40, 32'd1, 8'd10, 6'd10);
        flush = 1'b1;
        step();
        flush = 1'b0; issue = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_drop_issue: valid %b exp 0", valid); end
`ifdef SCALU_MULDIV_EN
        wb_stall = 1'b1;
        drive(5'b00000, 32'd50, 32'd1, 8'd11, 6'd11);
        step();
        drive(5'b10010, 32'd100, 32'd7, 8'd12, 6'd12);
        step();
        issue = 1'b0;
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (valid !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL flush_busy: valid %b stall %b exp 0 0", valid, stall);
        end
        wb_stall = 1'b0;
        for (int c = 0; c < XLEN + 4; c++) begin
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_stale cyc %0d: valid %b exp 0", c, valid); end
            step();
        end
        drive(5'b10010, 32'd100, 32'd7, 8'd13, 6'd13);
        step();
        issue = 1'b0;
        repeat (XLEN) step();
        checks++; if (valid !== 1'b1 || o_result !== 32'd14 || o_robid !== 8'd13) begin
            errors++; $display("FAIL flush_recover: valid %b result %h robid %0d exp 1 e 13", valid, o_result, o_robid);
        end
        step();
`else
        for (int c = 0; c < 4; c++) begin
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_stale cyc %0d: valid %b exp 0", c, valid); end
            step();
        end
`endif
    endtask

    task automatic test_reset_mid();
        wb_stall = 1'b1;
        drive(5'b10100, 32'd1, 32'd1, 8'h3C, 6'h1E);
        step();
`ifdef SCALU_MULDIV_EN
        drive(5'b10000, 32'd3, 32'd3, 8'h3D, 6'h1F);
        step();
        issue = 1'b0;
        repeat (5) step();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_busy: stall %b exp 1", stall); end
`else
        issue = 1'b0;
        step();
`endif
        checks++; if (valid !== 1'b1 || err !== 1'b1 || o_robid !== 8'h3C) begin
            errors++; $display("FAIL rstmid_pre: valid %b err %b robid %h exp 1 1 3c", valid, err, o_robid);
        end
        #2 rst = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || stall !== 1'b0 || err !== 1'b0 || ecause !== 5'd0) begin
            errors++; $display("FAIL rstmid_ctrl: v%b s%b e%b c%0d exp 0 0 0 0", valid, stall, err, ecause);
        end
        checks++; if (o_robid !== 8'd0 || o_rd !== 6'd0 || o_result !== 32'd0) begin
            errors++; $display("FAIL rstmid_data: robid %h rd %h result %h exp 0", o_robid, o_rd, o_result);
        end
        step();
        rst = 1'b1;
        wb_stall = 1'b0;
        step();
        drive(5'b00000, 32'd2, 32'd3, 8'h44, 6'h04);
        step();
        issue = 1'b0;
        checks++; if (valid !== 1'b1 || o_result !== 32'd5 || o_robid !== 8'h44) begin
            errors++; $display("FAIL rstmid_after: valid %b result %h robid %h exp 1 5 44", valid, o_result, o_robid);
        end
        step();
`ifdef SCALU_MULDIV_EN
        drive(5'b10000, 32'd6, 32'd7, 8'h45, 6'h05);
        step();
        issue = 1'b0;
        repeat (XLEN) step();
        checks++; if (valid !== 1'b1 || o_result !== 32'd42) begin
            errors++; $display("FAIL rstmid_md_after: valid %b result %h exp 1 2a", valid, o_result);
        end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_illegal();
        test_muldiv();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
